// File: rtl/mult_share_arbiter.sv
// Round-robin share of one pipelined multiplier between NUM_REQ requesters; define MULT_SHARE_ARBITER_FIXED_PRIO_EN for fixed priority.
// Result valid MULT_LATENCY+1 enabled cycles after accept; a pending unpopped result blocks its requester's next grant.
module mult_share_arbiter #(
   parameter int DATA_WIDTH   = 16,
   parameter int NUM_REQ      = 2,
   parameter int MULT_LATENCY = 2
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic                              i_en,
   input  logic [NUM_REQ-1:0]                iv_req_valid,
   output logic [NUM_REQ-1:0]                ov_req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     iv_req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     iv_req_b,
   output logic [DATA_WIDTH-1:0]             ov_mult_a,
   output logic [DATA_WIDTH-1:0]             ov_mult_b,
   input  logic [2*DATA_WIDTH-1:0]           iv_mult_prod,
   output logic [NUM_REQ-1:0]                ov_res_valid,
   input  logic [NUM_REQ-1:0]                iv_res_ready,
   output logic [NUM_REQ*2*DATA_WIDTH-1:0]   ov_res_prod,
   output logic                              ov_busy
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_INFLIGHT = 2'd1;
   localparam logic [1:0] ST_DONE     = 2'd2;

   logic [NUM_REQ-1:0][1:0]            r_state;
   logic [NUM_REQ-1:0][2*DATA_WIDTH-1:0] r_res_prod;
   logic [DATA_WIDTH-1:0]              r_mult_a;
   logic [DATA_WIDTH-1:0]              r_mult_b;
   // Stage 0 is aligned with the operand register, so the tail lines up with iv_mult_prod.
   logic [MULT_LATENCY:0]              r_tag_vld;
   logic [MULT_LATENCY:0][IW-1:0]      r_tag_id;

   logic [NUM_REQ-1:0] w_elig;
   logic [NUM_REQ-1:0] w_gnt;
   logic [IW-1:0]      w_gnt_idx;
   logic               w_accept;
   logic               w_cap;
   logic [IW-1:0]      w_cap_id;

   always_comb begin
      w_elig = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_elig[i] = iv_req_valid[i] & (r_state[i] == ST_IDLE) & i_en & i_rst_n;
      end
   end

`ifdef MULT_SHARE_ARBITER_FIXED_PRIO_EN
   always_comb begin
      w_gnt     = '0;
      w_gnt_idx = '0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (w_elig[i]) begin
            w_gnt     = '0;
            w_gnt[i]  = 1'b1;
            w_gnt_idx = IW'(i);
         end
      end
   end
`else
   logic [IW-1:0] r_last;
   logic [IW:0]   w_cand;
   logic          w_found;

   always_comb begin
      w_gnt     = '0;
      w_gnt_idx = '0;
      w_found   = 1'b0;
      w_cand    = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         w_cand = {1'b0, r_last} + (IW+1)'(off);
         if (w_cand >= (IW+1)'(NUM_REQ)) begin
            w_cand = w_cand - (IW+1)'(NUM_REQ);
         end
         if (!w_found && w_elig[w_cand[IW-1:0]]) begin
            w_found                 = 1'b1;
            w_gnt[w_cand[IW-1:0]]   = 1'b1;
            w_gnt_idx               = w_cand[IW-1:0];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last <= IW'(NUM_REQ-1);
      end else if (w_accept) begin
         r_last <= w_gnt_idx;
      end
   end
`endif

   assign w_accept     = |w_gnt;
   assign ov_req_ready = w_gnt;
   assign w_cap        = i_en & r_tag_vld[MULT_LATENCY];
   assign w_cap_id     = r_tag_id[MULT_LATENCY];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mult_a  <= '0;
         r_mult_b  <= '0;
         r_tag_vld <= '0;
         r_tag_id  <= '0;
      end else if (i_en) begin
         r_tag_vld <= {r_tag_vld[MULT_LATENCY-1:0], w_accept};
         r_tag_id  <= {r_tag_id[MULT_LATENCY-1:0], w_gnt_idx};
         if (w_accept) begin
            r_mult_a <= iv_req_a[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            r_mult_b <= iv_req_b[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= '0;
         r_res_prod <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            case (r_state[i])
               ST_IDLE: begin
                  if (w_gnt[i]) r_state[i] <= ST_INFLIGHT;
               end
               ST_INFLIGHT: begin
                  if (w_cap && (w_cap_id == IW'(i))) begin
                     r_state[i]    <= ST_DONE;
                     r_res_prod[i] <= iv_mult_prod;
                  end
               end
               ST_DONE: begin
                  if (i_en && iv_res_ready[i]) r_state[i] <= ST_IDLE;
               end
               default: r_state[i] <= ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      ov_res_valid = '0;
      ov_busy      = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         ov_res_valid[i] = (r_state[i] == ST_DONE);
         ov_busy         = ov_busy | (r_state[i] != ST_IDLE);
      end
   end

   assign ov_mult_a   = r_mult_a;
   assign ov_mult_b   = r_mult_b;
   assign ov_res_prod = r_res_prod;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: table vectors, directed corner sequences and random traffic
// against a queue-based model of outstanding operations.
module tb_mult_share_arbiter;
   localparam int DW = 16;
   localparam int N  = 2;
   localparam int L  = 2;
   localparam int M_IDLE = 0, M_INFL = 1, M_DONE = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n = 1'b1;
   logic              en = 1'b1;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_ready;
   logic [N*DW-1:0]   req_a = '0;
   logic [N*DW-1:0]   req_b = '0;
   logic [DW-1:0]     mult_a, mult_b;
   logic [2*DW-1:0]   mult_prod;
   logic [N-1:0]      res_valid;
   logic [N-1:0]      res_ready = '0;
   logic [N*2*DW-1:0] res_prod;
   logic              busy;

   mult_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .MULT_LATENCY(L)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
      .iv_req_valid(req_valid), .ov_req_ready(req_ready),
      .iv_req_a(req_a), .iv_req_b(req_b),
      .ov_mult_a(mult_a), .ov_mult_b(mult_b), .iv_mult_prod(mult_prod),
      .ov_res_valid(res_valid), .iv_res_ready(res_ready),
      .ov_res_prod(res_prod), .ov_busy(busy)
   );

   // Stand-in for the shared pipelined signed multiplier, enabled with the arbiter.
   logic [2*DW-1:0] mp [0:L-1];
   always @(posedge clk) begin
      if (en) begin
         mp[0] <= $signed(mult_a) * $signed(mult_b);
         for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
      end
   end
   assign mult_prod = mp[L-1];

   typedef struct {
      int          id;
      logic [31:0] prod;
      int          cnt;
   } fl_t;

   int            m_state [N];
   logic [31:0]   m_prod  [N];
   int            m_last;
   logic [DW-1:0] m_ma, m_mb;
   fl_t           flq[$];

   int tests = 0;
   int failed = 0;
   logic [N-1:0]  seen_rvalid, seen_ready;
   logic [63:0]   seen_prod;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] smul(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic signed [DW-1:0]   sa, sb;
      logic signed [2*DW-1:0] p;
      sa = a;
      sb = b;
      p  = sa * sb;
      return p;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_state[i] = M_IDLE;
         m_prod[i]  = '0;
      end
      flq.delete();
      m_last = N - 1;
      m_ma = '0;
      m_mb = '0;
   endtask

   function automatic logic [N-1:0] model_grant();
      logic [N-1:0] g;
      int idx;
      g = '0;
      if (en && rst_n) begin
         for (int off = 1; off <= N; off++) begin
            idx = (m_last + off) % N;
            if (g == '0 && req_valid[idx] && m_state[idx] == M_IDLE) g[idx] = 1'b1;
         end
      end
      return g;
   endfunction

   // One enabled edge: pending results may be popped, each outstanding op ages by one,
   // and the granted requester's op starts its L+1 edge trip to the result register.
   task automatic model_advance(input logic [N-1:0] g);
      fl_t nq[$];
      fl_t e;
      if (!en) return;
      for (int i = 0; i < N; i++)
         if (m_state[i] == M_DONE && res_ready[i]) m_state[i] = M_IDLE;
      for (int j = 0; j < flq.size(); j++) begin
         e = flq[j];
         e.cnt--;
         if (e.cnt == 0) begin
            m_state[e.id] = M_DONE;
            m_prod[e.id]  = e.prod;
         end else begin
            nq.push_back(e);
         end
      end
      flq = nq;
      for (int i = 0; i < N; i++) begin
         if (g[i]) begin
            e.id   = i;
            e.prod = smul(req_a[i*DW +: DW], req_b[i*DW +: DW]);
            e.cnt  = L + 1;
            flq.push_back(e);
            m_state[i] = M_INFL;
            m_last = i;
            m_ma = req_a[i*DW +: DW];
            m_mb = req_b[i*DW +: DW];
         end
      end
   endtask

   // Called at posedge+1 with inputs applied; checks mid-cycle, then crosses one edge.
   task automatic step();
      logic [N-1:0]  eg, ev;
      logic [63:0]   ep;
      logic          eb;
      #4;
      eg = model_grant();
      ev = '0;
      ep = '0;
      eb = 1'b0;
      for (int i = 0; i < N; i++) begin
         ev[i] = (m_state[i] == M_DONE);
         eb    = eb | (m_state[i] != M_IDLE);
         ep[i*32 +: 32] = m_prod[i];
      end
      chk("req_ready", req_ready, eg);
      chk("res_valid", res_valid, ev);
      chk("res_prod", res_prod, ep);
      chk("busy", busy, eb);
      chk("mult_a", mult_a, m_ma);
      chk("mult_b", mult_b, m_mb);
      seen_rvalid = res_valid;
      seen_ready  = req_ready;
      seen_prod   = res_prod;
      @(posedge clk);
      model_advance(eg);
      #1;
   endtask

   // Reset asserted mid-cycle with requests pending: everything must drop at once.
   task automatic do_reset();
      req_valid = '1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready", req_ready, '0);
      chk("rst_valid", res_valid, '0);
      chk("rst_prod", res_prod, '0);
      chk("rst_busy", busy, '0);
      chk("rst_mult_a", mult_a, '0);
      chk("rst_mult_b", mult_b, '0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req_valid = '0;
   endtask

   typedef struct {
      logic        rst;
      logic [1:0]  vld, rrdy;
      logic [15:0] a0, b0, a1, b1;
      logic [1:0]  x_rdy, x_rv;
      logic        chk_p;
      int          p_sel;
      logic [31:0] x_p;
   } vec_t;
   vec_t tv[$];

   task automatic add(input logic rst, input logic [1:0] vld, input logic [1:0] rrdy,
                      input logic [15:0] a0, input logic [15:0] b0,
                      input logic [15:0] a1, input logic [15:0] b1,
                      input logic [1:0] x_rdy, input logic [1:0] x_rv,
                      input logic chk_p, input int p_sel, input logic [31:0] x_p);
      vec_t v;
      v = '{rst, vld, rrdy, a0, b0, a1, b1, x_rdy, x_rv, chk_p, p_sel, x_p};
      tv.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int w, acc0, first;
      logic [31:0] first_prod;
      logic anyrv;

      // Single op: 7 * -3, held until popped.
      add(1, 2'b01, 2'b00, 16'h0007, 16'hFFFD, 16'h0, 16'h0, 2'b01, 2'b00, 0, 0, 32'h0);
      add(0, 2'b00, 2'b00, 16'h0007, 16'hFFFD, 16'h0, 16'h0, 2'b00, 2'b00, 0, 0, 32'h0);
      add(0, 2'b00, 2'b00, 16'h0007, 16'hFFFD, 16'h0, 16'h0, 2'b00, 2'b00, 0, 0, 32'h0);
      add(0, 2'b00, 2'b00, 16'h0007, 16'hFFFD, 16'h0, 16'h0, 2'b00, 2'b00, 0, 0, 32'h0);
      add(0, 2'b00, 2'b00, 16'h0007, 16'hFFFD, 16'h0, 16'h0, 2'b00, 2'b01, 1, 0, 32'hFFFFFFEB);
      add(0, 2'b00, 2'b01, 16'h0007, 16'hFFFD, 16'h0, 16'h0, 2'b00, 2'b01, 1, 0, 32'hFFFFFFEB);
      add(0, 2'b00, 2'b00, 16'h0007, 16'hFFFD, 16'h0, 16'h0, 2'b00, 2'b00, 0, 0, 32'h0);
      // Contention: grants 0,1,0,1; pop plus re-request on req0 gives no grant that cycle.
      add(1, 2'b11, 2'b11, 16'h0100, 16'h0100, 16'hFFFF, 16'h0002, 2'b01, 2'b00, 0, 0, 32'h0);
      add(0, 2'b11, 2'b11, 16'h0100, 16'h0100, 16'hFFFF, 16'h0002, 2'b10, 2'b00, 0, 0, 32'h0);
      add(0, 2'b11, 2'b11, 16'h0100, 16'h0100, 16'hFFFF, 16'h0002, 2'b00, 2'b00, 0, 0, 32'h0);
      add(0, 2'b11, 2'b11, 16'h0100, 16'h0100, 16'hFFFF, 16'h0002, 2'b00, 2'b00, 0, 0, 32'h0);
      add(0, 2'b11, 2'b11, 16'h0100, 16'h0100, 16'hFFFF, 16'h0002, 2'b00, 2'b01, 1, 0, 32'h00010000);
      add(0, 2'b11, 2'b11, 16'h0100, 16'h0100, 16'hFFFF, 16'h0002, 2'b01, 2'b10, 1, 1, 32'hFFFFFFFE);
      add(0, 2'b11, 2'b11, 16'h0100, 16'h0100, 16'hFFFF, 16'h0002, 2'b10, 2'b00, 0, 0, 32'h0);
      add(0, 2'b11, 2'b11, 16'h0100, 16'h0100, 16'hFFFF, 16'h0002, 2'b00, 2'b00, 0, 0, 32'h0);
      add(0, 2'b11, 2'b11, 16'h0100, 16'h0100, 16'hFFFF, 16'h0002, 2'b00, 2'b00, 0, 0, 32'h0);
      add(0, 2'b11, 2'b11, 16'h0100, 16'h0100, 16'hFFFF, 16'h0002, 2'b00, 2'b01, 1, 0, 32'h00010000);

      model_reset();
      @(posedge clk);
      #1;
      for (int i = 0; i < tv.size(); i++) begin
         if (tv[i].rst) do_reset();
         en        = 1'b1;
         req_valid = tv[i].vld;
         res_ready = tv[i].rrdy;
         req_a     = {tv[i].a1, tv[i].a0};
         req_b     = {tv[i].b1, tv[i].b0};
         step();
         chk($sformatf("tv%0d_ready", i), seen_ready, tv[i].x_rdy);
         chk($sformatf("tv%0d_rvalid", i), seen_rvalid, tv[i].x_rv);
         if (tv[i].chk_p) chk($sformatf("tv%0d_prod", i), seen_prod[tv[i].p_sel*32 +: 32], tv[i].x_p);
      end

      // Backpressure on requester 1 while requester 0 keeps being served.
      do_reset();
      res_ready = 2'b00;
      req_valid = 2'b10;
      req_a = {16'd3, 16'h0011};
      req_b = {16'd5, 16'h0002};
      step();
      req_valid = 2'b00;
      w = 0;
      while (w < 20 && !seen_rvalid[1]) begin
         step();
         w++;
      end
      chk("bp_wait_in_bound", (w < 20), 1);
      req_valid = 2'b11;
      res_ready = 2'b01;
      acc0 = 0;
      for (int s = 0; s < 10; s++) begin
         step();
         chk("bp_rvalid1", seen_rvalid[1], 1);
         chk("bp_prod1", seen_prod[63:32], 32'd15);
         chk("bp_ready1", seen_ready[1], 0);
         if (seen_ready[0]) acc0++;
      end
      chk("bp_req0_served", (acc0 >= 2), 1);
      req_valid = 2'b00;
      res_ready = 2'b11;
      for (int s = 0; s < 6; s++) step();

      // Enable freeze for three cycles while one op is in flight.
      do_reset();
      res_ready = 2'b01;
      req_valid = 2'b01;
      req_a = {16'h0, 16'h1234};
      req_b = {16'h0, 16'h0010};
      step();
      req_valid = 2'b00;
      first = -1;
      first_prod = '0;
      for (int s = 1; s <= 20; s++) begin
         en = (s >= 2 && s <= 4) ? 1'b0 : 1'b1;
         step();
         if (first < 0 && seen_rvalid[0]) begin
            first = s;
            first_prod = seen_prod[31:0];
         end
      end
      en = 1'b1;
      chk("frz_latency", first, 7);
      chk("frz_prod", first_prod, 32'h00012340);

      // Reset one cycle after accept: the dropped op must never return.
      do_reset();
      res_ready = 2'b00;
      req_valid = 2'b01;
      req_a = {16'h0, 16'd5};
      req_b = {16'h0, 16'd6};
      step();
      req_valid = 2'b00;
      step();
      do_reset();
      anyrv = 1'b0;
      for (int s = 0; s < 8; s++) begin
         step();
         anyrv = anyrv | (|seen_rvalid);
      end
      chk("rst_dropped_op", anyrv, 0);

      // Random traffic against the model.
      do_reset();
      for (int s = 0; s < 400; s++) begin
         if (s == 200) do_reset();
         en        = ($urandom_range(0, 7) != 0);
         req_valid = N'($urandom);
         res_ready = ($urandom_range(0, 3) == 0) ? N'(0) : N'($urandom);
         req_a     = $urandom;
         req_b     = $urandom;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
